// File: rtl/micro_decode_queue.sv
// micro_decode_queue: decodes 32-bit MIPS instructions into micro-ops
// {class, wb_en, dst, ill}. The micro-ops are buffered in a DEPTH-entry FIFO
// that sits between the fetch and issue stages.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  discard every queued micro-op on the next edge
//   in_valid/in_ready/ins  instruction push handshake
//   out_valid/out_ready    head-of-queue pop handshake
//   uop_class/wb_en/dst/ill  head micro-op (registered; all zero when empty)
//   ill_cnt                saturating count of accepted illegal instructions
// Class codes are enumerated locally. Keep them in step with the INS_*
// table used by the issue stage.
module micro_decode_queue #(
  parameter int unsigned INS_W     = 6,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LINK_REG  = 31,
  parameter int unsigned ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          ins,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INS_W-1:0]     uop_class,
  output logic                 uop_wb_en,
  output logic [REG_W-1:0]     uop_dst,
  output logic                 uop_ill,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = INS_W + REG_W + 2;

  // Micro-op class codes
  localparam int unsigned C_NOP   = 0,  C_ADD   = 1,  C_ADDU  = 2,  C_SUB   = 3;
  localparam int unsigned C_SUBU  = 4,  C_AND   = 5,  C_OR    = 6,  C_XOR   = 7;
  localparam int unsigned C_NOR   = 8,  C_SLT   = 9,  C_SLTU  = 10, C_SLL   = 11;
  localparam int unsigned C_SRL   = 12, C_SRA   = 13, C_SLLV  = 14, C_SRLV  = 15;
  localparam int unsigned C_SRAV  = 16, C_JR    = 17, C_JALR  = 18, C_J     = 19;
  localparam int unsigned C_JAL   = 20, C_BEQ   = 21, C_BNE   = 22, C_BLEZ  = 23;
  localparam int unsigned C_BGTZ  = 24, C_BLTZ  = 25, C_BGEZ  = 26, C_LB    = 27;
  localparam int unsigned C_LH    = 28, C_LW    = 29, C_LBU   = 30, C_LHU   = 31;
  localparam int unsigned C_SB    = 32, C_SH    = 33, C_SW    = 34, C_ADDI  = 35;
  localparam int unsigned C_ADDIU = 36, C_SLTI  = 37, C_SLTIU = 38, C_ANDI  = 39;
  localparam int unsigned C_ORI   = 40, C_XORI  = 41, C_LUI   = 42;

  // Instruction fields
  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  logic       unused_fields;
  assign op    = ins[31:26];
  assign rt    = ins[20:16];
  assign rd    = ins[15:11];
  assign funct = ins[5:0];
  assign unused_fields = ^{ins[25:21], ins[10:6]};

  // Combinational decode of the incoming instruction
  logic [INS_W-1:0] dec_cls;
  logic             dec_wb;
  logic [REG_W-1:0] dec_dst;
  logic             dec_ill;
  logic [ENT_W-1:0] dec_ent;
  int unsigned      cls_raw;
  logic             wr_rd, wr_rt, wr_link;

  always_comb begin
    cls_raw = C_NOP;
    wr_rd   = 1'b0;
    wr_rt   = 1'b0;
    wr_link = 1'b0;
    dec_ill = 1'b0;
    case (op)
      6'h00: begin
        wr_rd = 1'b1;
        case (funct)
          6'h00: cls_raw = C_SLL;
          6'h02: cls_raw = C_SRL;
          6'h03: cls_raw = C_SRA;
          6'h04: cls_raw = C_SLLV;
          6'h06: cls_raw = C_SRLV;
          6'h07: cls_raw = C_SRAV;
          6'h08: begin cls_raw = C_JR; wr_rd = 1'b0; end
          6'h09: cls_raw = C_JALR;
          6'h20: cls_raw = C_ADD;
          6'h21: cls_raw = C_ADDU;
          6'h22: cls_raw = C_SUB;
          6'h23: cls_raw = C_SUBU;
          6'h24: cls_raw = C_AND;
          6'h25: cls_raw = C_OR;
          6'h26: cls_raw = C_XOR;
          6'h27: cls_raw = C_NOR;
          6'h2A: cls_raw = C_SLT;
          6'h2B: cls_raw = C_SLTU;
          default: begin dec_ill = 1'b1; wr_rd = 1'b0; end
        endcase
      end
      6'h01: begin
        if (rt == 5'd0)      cls_raw = C_BLTZ;
        else if (rt == 5'd1) cls_raw = C_BGEZ;
        else                 dec_ill = 1'b1;
      end
      6'h02: cls_raw = C_J;
      6'h03: begin cls_raw = C_JAL; wr_link = 1'b1; end
      6'h04: cls_raw = C_BEQ;
      6'h05: cls_raw = C_BNE;
      6'h06: cls_raw = C_BLEZ;
      6'h07: cls_raw = C_BGTZ;
      6'h08: begin cls_raw = C_ADDI;  wr_rt = 1'b1; end
      6'h09: begin cls_raw = C_ADDIU; wr_rt = 1'b1; end
      6'h0A: begin cls_raw = C_SLTI;  wr_rt = 1'b1; end
      6'h0B: begin cls_raw = C_SLTIU; wr_rt = 1'b1; end
      6'h0C: begin cls_raw = C_ANDI;  wr_rt = 1'b1; end
      6'h0D: begin cls_raw = C_ORI;   wr_rt = 1'b1; end
      6'h0E: begin cls_raw = C_XORI;  wr_rt = 1'b1; end
      6'h0F: begin cls_raw = C_LUI;   wr_rt = 1'b1; end
      6'h20: begin cls_raw = C_LB;    wr_rt = 1'b1; end
      6'h21: begin cls_raw = C_LH;    wr_rt = 1'b1; end
      6'h23: begin cls_raw = C_LW;    wr_rt = 1'b1; end
      6'h24: begin cls_raw = C_LBU;   wr_rt = 1'b1; end
      6'h25: begin cls_raw = C_LHU;   wr_rt = 1'b1; end
      6'h28: cls_raw = C_SB;
      6'h29: cls_raw = C_SH;
      6'h2B: cls_raw = C_SW;
      default: dec_ill = 1'b1;
    endcase

    dec_cls = INS_W'(cls_raw);
    if (wr_link)    dec_dst = REG_W'(LINK_REG);
    else if (wr_rt) dec_dst = REG_W'(rt);
    else if (wr_rd) dec_dst = REG_W'(rd);
    else            dec_dst = '0;
    // A write to register 0 is no write at all; dst is never left undefined
    dec_wb = (dec_dst != '0);
    dec_ent = {dec_ill, dec_wb, dec_dst, dec_cls};
  end

  // FIFO storage and control
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CNT_W-1:0] count, cnt_nxt;
  logic [ENT_W-1:0] head, head_nxt;
  logic             push, pop;

  assign in_ready = (count != CNT_W'(DEPTH)) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Next pointers, occupancy and registered head image
  always_comb begin
    rd_nxt  = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_nxt  = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    cnt_nxt = count + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      rd_nxt  = '0;
      wr_nxt  = '0;
      cnt_nxt = '0;
    end
    // The slot being written this cycle may become the head, so bypass it
    if (cnt_nxt == '0)                 head_nxt = '0;
    else if (push && (rd_nxt == wr_ptr)) head_nxt = dec_ent;
    else                               head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head      <= '0;
      out_valid <= 1'b0;
      ill_cnt   <= '0;
    end else begin
      if (push) mem[wr_ptr] <= dec_ent;
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      count     <= cnt_nxt;
      head      <= head_nxt;
      out_valid <= (cnt_nxt != '0);
      if (push && dec_ill && (ill_cnt != '1)) ill_cnt <= ill_cnt + ILL_CNT_W'(1);
    end
  end

  assign {uop_ill, uop_wb_en, uop_dst, uop_class} = head;

endmodule

// File: tb/tb_micro_decode_queue.sv
// Testbench for micro_decode_queue: directed scenarios plus random traffic,
// checked by a scoreboard fed from a behavioural decode/queue model.
module tb_micro_decode_queue;

  localparam int DEPTH = 4;

  // Class codes expected on uop_class
  localparam int C_NOP = 0, C_ADD = 1, C_ADDU = 2, C_SUB = 3, C_SUBU = 4, C_AND = 5;
  localparam int C_OR = 6, C_XOR = 7, C_NOR = 8, C_SLT = 9, C_SLTU = 10, C_SLL = 11;
  localparam int C_SRL = 12, C_SRA = 13, C_SLLV = 14, C_SRLV = 15, C_SRAV = 16;
  localparam int C_JR = 17, C_JALR = 18, C_J = 19, C_JAL = 20, C_BEQ = 21, C_BNE = 22;
  localparam int C_BLEZ = 23, C_BGTZ = 24, C_BLTZ = 25, C_BGEZ = 26, C_LB = 27;
  localparam int C_LH = 28, C_LW = 29, C_LBU = 30, C_LHU = 31, C_SB = 32, C_SH = 33;
  localparam int C_SW = 34, C_ADDI = 35, C_ADDIU = 36, C_SLTI = 37, C_SLTIU = 38;
  localparam int C_ANDI = 39, C_ORI = 40, C_XORI = 41, C_LUI = 42;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] ins;
  logic        in_ready, out_valid, uop_wb_en, uop_ill;
  logic [5:0]  uop_class;
  logic [4:0]  uop_dst;
  logic [15:0] ill_cnt;

  micro_decode_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
    .out_valid(out_valid), .out_ready(out_ready),
    .uop_class(uop_class), .uop_wb_en(uop_wb_en), .uop_dst(uop_dst),
    .uop_ill(uop_ill), .ill_cnt(ill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct { int cls; bit wb; int dst; bit ill; } exp_t;
  exp_t q[$];
  int   m_count = 0;
  int   m_ill   = 0;

  // Decode tables: R-type by funct, others by opcode (dst kind 0 none, 1 rt, 2 link)
  int r_cls[int];
  bit r_wr[int];
  int o_cls[int];
  int o_dst[int];
  int ops_list[$];
  int fn_list[$];

  task automatic add_r(input int fn, input int cls, input bit wr);
    r_cls[fn] = cls; r_wr[fn] = wr; fn_list.push_back(fn);
  endtask

  task automatic add_o(input int op, input int cls, input int dk);
    o_cls[op] = cls; o_dst[op] = dk; ops_list.push_back(op);
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int op, fn, rt, rd;
    op = int'(w[31:26]); fn = int'(w[5:0]); rt = int'(w[20:16]); rd = int'(w[15:11]);
    e = '{C_NOP, 1'b0, 0, 1'b1};
    if (op == 0) begin
      if (r_cls.exists(fn)) begin
        e.cls = r_cls[fn]; e.wb = r_wr[fn]; e.dst = rd; e.ill = 1'b0;
      end
    end else if (op == 1) begin
      if (rt < 2) begin
        e.cls = (rt == 0) ? C_BLTZ : C_BGEZ; e.ill = 1'b0;
      end
    end else if (o_cls.exists(op)) begin
      e.cls = o_cls[op]; e.ill = 1'b0;
      if (o_dst[op] == 1) begin e.wb = 1'b1; e.dst = rt; end
      if (o_dst[op] == 2) begin e.wb = 1'b1; e.dst = 31; end
    end
    if (e.dst == 0) e.wb = 1'b0;
    if (!e.wb) e.dst = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: applies each edge's push/pop/flush to the model, just after the sampling point
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        q.delete(); m_count = 0; m_ill = 0;
      end else if (flush) begin
        q.delete(); m_count = 0;
      end else begin
        bit pu, po;
        exp_t e;
        pu = in_valid && (m_count < DEPTH);
        po = out_ready && (m_count > 0);
        if (pu) begin
          e = ref_decode(ins);
          q.push_back(e);
          if (e.ill && m_ill < 65535) m_ill++;
        end
        m_count = m_count + int'(pu) - int'(po);
      end
    end
  end

  // Monitor: compares DUT outputs with the model and pops on each consumed head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("out_valid", 32'(out_valid), 32'(m_count != 0));
        check("in_ready", 32'(in_ready), 32'((m_count < DEPTH) && !flush));
        check("ill_cnt", 32'(ill_cnt), 32'(m_ill));
        if (out_valid) begin
          if (q.size() == 0) begin
            check("head_unexpected", 32'(out_valid), 32'd0);
          end else begin
            check("head_class", 32'(uop_class), 32'(q[0].cls));
            check("head_wb_en", 32'(uop_wb_en), 32'(q[0].wb));
            check("head_dst",   32'(uop_dst),   32'(q[0].dst));
            check("head_ill",   32'(uop_ill),   32'(q[0].ill));
            if (out_ready) void'(q.pop_front());
          end
        end else begin
          check("idle_uop", {14'd0, uop_class, uop_wb_en, uop_dst, uop_ill}, 32'd0);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] i, input logic rdy, input logic fl);
    in_valid = v; ins = i; out_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(9, 0);
    if (r < 4) begin
      w[31:26] = 6'd0;
      w[5:0]   = 6'(fn_list[$urandom_range(fn_list.size() - 1, 0)]);
    end else if (r < 8) begin
      w[31:26] = 6'(ops_list[$urandom_range(ops_list.size() - 1, 0)]);
    end else if (r == 8) begin
      w[31:26] = 6'd1;
      w[20:16] = 5'($urandom_range(2, 0));
    end
    if ($urandom_range(7, 0) == 0) w[20:16] = 5'd0;
    return w;
  endfunction

  int ill_before;

  initial begin
    add_r('h00, C_SLL, 1);  add_r('h02, C_SRL, 1);  add_r('h03, C_SRA, 1);
    add_r('h04, C_SLLV, 1); add_r('h06, C_SRLV, 1); add_r('h07, C_SRAV, 1);
    add_r('h08, C_JR, 0);   add_r('h09, C_JALR, 1); add_r('h20, C_ADD, 1);
    add_r('h21, C_ADDU, 1); add_r('h22, C_SUB, 1);  add_r('h23, C_SUBU, 1);
    add_r('h24, C_AND, 1);  add_r('h25, C_OR, 1);   add_r('h26, C_XOR, 1);
    add_r('h27, C_NOR, 1);  add_r('h2A, C_SLT, 1);  add_r('h2B, C_SLTU, 1);
    add_o('h02, C_J, 0);    add_o('h03, C_JAL, 2);  add_o('h04, C_BEQ, 0);
    add_o('h05, C_BNE, 0);  add_o('h06, C_BLEZ, 0); add_o('h07, C_BGTZ, 0);
    add_o('h08, C_ADDI, 1); add_o('h09, C_ADDIU, 1); add_o('h0A, C_SLTI, 1);
    add_o('h0B, C_SLTIU, 1); add_o('h0C, C_ANDI, 1); add_o('h0D, C_ORI, 1);
    add_o('h0E, C_XORI, 1); add_o('h0F, C_LUI, 1);  add_o('h20, C_LB, 1);
    add_o('h21, C_LH, 1);   add_o('h23, C_LW, 1);   add_o('h24, C_LBU, 1);
    add_o('h25, C_LHU, 1);  add_o('h28, C_SB, 0);   add_o('h29, C_SH, 0);
    add_o('h2B, C_SW, 0);

    rst_n = 1'b0; in_valid = 1'b0; ins = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_uop", {14'd0, uop_class, uop_wb_en, uop_dst, uop_ill}, 32'd0);
    check("rst_ill_cnt", 32'(ill_cnt), 32'd0);
    rst_n = 1'b1;

    // add $8,$9,$10 into an empty queue: visible after one edge
    cyc(1'b1, 32'h012A4020, 1'b0, 1'b0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_class", 32'(uop_class), 32'(C_ADD));
    check("add_wb", 32'(uop_wb_en), 32'd1);
    check("add_dst", 32'(uop_dst), 32'd8);
    check("add_ill", 32'(uop_ill), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // lw / jal / bgez in order
    cyc(1'b1, 32'h8D280004, 1'b0, 1'b0);
    cyc(1'b1, 32'h0C000010, 1'b0, 1'b0);
    cyc(1'b1, 32'h04010003, 1'b0, 1'b0);
    check("lw_head_class", 32'(uop_class), 32'(C_LW));
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    // Two illegal encodings
    cyc(1'b1, 32'hFC000000, 1'b0, 1'b0);
    cyc(1'b1, 32'h04020000, 1'b0, 1'b0);
    check("ill_cnt_two", 32'(ill_cnt), 32'd2);
    check("ill_head_class", 32'(uop_class), 32'(C_NOP));
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Fill to DEPTH, hold a fifth until one pop
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h01095020 + 32'(i << 11), 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 32'h8D2B0000, 1'b0, 1'b0);
    check("full_hold_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 32'h8D2B0000, 1'b1, 1'b0);
    check("after_pop_ready", 32'(in_ready), 32'd1);
    cyc(1'b1, 32'h8D2B0000, 1'b0, 1'b0);
    check("refill_ready", 32'(in_ready), 32'd0);
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);

    // Push, pop and flush together with two entries queued
    cyc(1'b1, 32'h012A4020, 1'b0, 1'b0);
    cyc(1'b1, 32'h8D280004, 1'b0, 1'b0);
    ill_before = int'(ill_cnt);
    cyc(1'b1, 32'hFC000000, 1'b1, 1'b1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ill_cnt", 32'(ill_cnt), 32'(ill_before));
    check("flush_uop", {14'd0, uop_class, uop_wb_en, uop_dst, uop_ill}, 32'd0);

    // addi to $0 writes nothing; async reset clears mid-queue
    cyc(1'b1, 32'h20000001, 1'b0, 1'b0);
    check("addi0_class", 32'(uop_class), 32'(C_ADDI));
    check("addi0_wb", 32'(uop_wb_en), 32'd0);
    check("addi0_dst", 32'(uop_dst), 32'd0);
    cyc(1'b1, 32'h8D280004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ill_cnt", 32'(ill_cnt), 32'd0);
    check("arst_uop", {14'd0, uop_class, uop_wb_en, uop_dst, uop_ill}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(3, 0) != 0, rand_ins(), $urandom_range(9, 0) < 7,
          $urandom_range(39, 0) == 0);

    repeat (DEPTH + 2) cyc(1'b0, '0, 1'b1, 1'b0);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_model", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
